// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. It passes ALU results through to
// write-back with one cycle of latency, and drives an SRAM-like data bus
// for loads and stores, with at most one transaction outstanding.
// Optional feature: define ADDR_EXC_EN to trap misaligned halfword and word
// accesses as address-error exceptions. With the macro undefined, addresses
// go out unchanged and the exception outputs are tied low.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_wd,
  input  logic        ex_reg,
  input  logic [63:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_sdata,
  input  logic        flush_i,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [4:0]  mem_wd,
  output logic        mem_reg,
  output logic [63:0] mem_wdata,
  output logic        exc_ade,
  output logic [31:0] exc_badvaddr
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t      state;
  state_t      state_next;
  logic        ex_is_mem;
  logic        ex_is_store;
  logic [1:0]  ex_size;
  logic [31:0] ex_store_data;
  logic        ex_misaligned;
  logic        accept;
  logic        launch;
  logic        complete;
  logic [3:0]  op_memop;
  logic [4:0]  op_wd;
  logic        op_reg;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [63:0] load_result;

  assign ex_ready = (state == IDLE);
  assign data_req = (state == REQ);
  assign accept   = ex_valid && ex_ready;

  // A bus transaction starts only for a clean, unflushed, aligned memory op.
  assign launch = accept && ex_is_mem && !flush_i && !ex_misaligned;

  // Decode the incoming memop into access size, direction and store lanes.
  always_comb begin
    ex_is_mem     = 1'b0;
    ex_is_store   = 1'b0;
    ex_size       = 2'd0;
    ex_store_data = 32'd0;
    case (ex_memop)
      OP_LB, OP_LBU: begin
        ex_is_mem = 1'b1;
        ex_size   = 2'd0;
      end
      OP_LH, OP_LHU: begin
        ex_is_mem = 1'b1;
        ex_size   = 2'd1;
      end
      OP_LW: begin
        ex_is_mem = 1'b1;
        ex_size   = 2'd2;
      end
      OP_SB: begin
        ex_is_mem     = 1'b1;
        ex_is_store   = 1'b1;
        ex_size       = 2'd0;
        ex_store_data = {4{ex_sdata[7:0]}};
      end
      OP_SH: begin
        ex_is_mem     = 1'b1;
        ex_is_store   = 1'b1;
        ex_size       = 2'd1;
        ex_store_data = {2{ex_sdata[15:0]}};
      end
      OP_SW: begin
        ex_is_mem     = 1'b1;
        ex_is_store   = 1'b1;
        ex_size       = 2'd2;
        ex_store_data = ex_sdata;
      end
      default: ;
    endcase
  end

`ifdef ADDR_EXC_EN
  assign ex_misaligned = ex_is_mem &&
                         (((ex_size == 2'd1) && ex_addr[0]) ||
                          ((ex_size == 2'd2) && (ex_addr[1:0] != 2'b00)));
`else
  assign ex_misaligned = 1'b0;
`endif

  // Next-state logic; a completion is only reported when nothing flushed it.
  always_comb begin
    state_next = state;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_next = REQ;
      end
      REQ: begin
        if (flush_i) begin
          if (data_addr_ok && data_data_ok) state_next = IDLE;
          else if (data_addr_ok)            state_next = DROP;
          else                              state_next = IDLE;
        end else if (data_addr_ok && data_data_ok) begin
          state_next = IDLE;
          complete   = 1'b1;
        end else if (data_addr_ok) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (data_data_ok) begin
          state_next = IDLE;
          complete   = !flush_i;
        end else if (flush_i) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (data_data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Capture the bus request and write-back tag when a transaction launches,
  // so the request stays stable for the whole handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'd0;
      data_wdata <= 32'd0;
      op_memop   <= 4'd0;
      op_wd      <= 5'd0;
      op_reg     <= 1'b0;
    end else if (launch) begin
      data_wr    <= ex_is_store;
      data_size  <= ex_size;
      data_addr  <= ex_addr;
      data_wdata <= ex_store_data;
      op_memop   <= ex_memop;
      op_wd      <= ex_wd;
      op_reg     <= ex_reg;
    end
  end

  // Pick the addressed byte/halfword out of the returned word and extend it.
  always_comb begin
    load_byte   = 8'd0;
    load_result = 64'd0;
    case (data_addr[1:0])
      2'd0: load_byte = data_rdata[7:0];
      2'd1: load_byte = data_rdata[15:8];
      2'd2: load_byte = data_rdata[23:16];
      2'd3: load_byte = data_rdata[31:24];
      default: load_byte = 8'd0;
    endcase
    load_half = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (op_memop)
      OP_LB:  load_result = {32'd0, {24{load_byte[7]}}, load_byte};
      OP_LBU: load_result = {32'd0, 24'd0, load_byte};
      OP_LH:  load_result = {32'd0, {16{load_half[15]}}, load_half};
      OP_LHU: load_result = {32'd0, 16'd0, load_half};
      OP_LW:  load_result = {32'd0, data_rdata};
      default: load_result = 64'd0;
    endcase
  end

  // Write-back register: pass-through results, bus completions, else bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wd    <= 5'd0;
      mem_reg   <= 1'b0;
      mem_wdata <= 64'd0;
    end else if (accept && !ex_is_mem && !flush_i) begin
      mem_wd    <= ex_wd;
      mem_reg   <= ex_reg;
      mem_wdata <= ex_wdata;
    end else if (complete) begin
      mem_wd    <= op_wd;
      mem_reg   <= data_wr ? 1'b0 : op_reg;
      mem_wdata <= data_wr ? 64'd0 : load_result;
    end else begin
      mem_wd    <= 5'd0;
      mem_reg   <= 1'b0;
      mem_wdata <= 64'd0;
    end
  end

`ifdef ADDR_EXC_EN
  // Raise a one-cycle address-error pulse and remember the faulting address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_ade      <= 1'b0;
      exc_badvaddr <= 32'd0;
    end else begin
      exc_ade <= accept && ex_misaligned && !flush_i;
      if (accept && ex_misaligned && !flush_i) exc_badvaddr <= ex_addr;
    end
  end
`else
  assign exc_ade      = 1'b0;
  assign exc_badvaddr = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage. The bench acts as the EX
// stage and the data-bus slave, and predicts the write-back outputs from
// instruction-level rules (load extension, store replication, flush kills).
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_wd;
  logic        ex_reg;
  logic [63:0] ex_wdata;
  logic [3:0]  ex_memop;
  logic [31:0] ex_addr;
  logic [31:0] ex_sdata;
  logic        flush_i;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [4:0]  mem_wd;
  logic        mem_reg;
  logic [63:0] mem_wdata;
  logic        exc_ade;
  logic [31:0] exc_badvaddr;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [4:0]  exp_wd    = 5'd0;
  logic        exp_reg   = 1'b0;
  logic [63:0] exp_wdata = 64'd0;
  logic        exp_ade   = 1'b0;
  logic [31:0] exp_bad   = 32'd0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wd(ex_wd), .ex_reg(ex_reg), .ex_wdata(ex_wdata), .ex_memop(ex_memop),
    .ex_addr(ex_addr), .ex_sdata(ex_sdata), .flush_i(flush_i),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_wd(mem_wd), .mem_reg(mem_reg), .mem_wdata(mem_wdata),
    .exc_ade(exc_ade), .exc_badvaddr(exc_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advance one cycle; write-back defaults to a bubble unless the caller
  // predicts a result for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    exp_wd    = 5'd0;
    exp_reg   = 1'b0;
    exp_wdata = 64'd0;
    exp_ade   = 1'b0;
  endtask

  function automatic logic [1:0] size_model(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2 || op == 4'd6) return 2'd0;
    if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [63:0] load_model(input logic [3:0] op,
                                             input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdata >> (8 * (addr % 4))) & 32'h0000_00FF;
    h = (rdata >> (16 * ((addr / 2) % 2))) & 32'h0000_FFFF;
    case (op)
      4'd1: return {32'd0, (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b};
      4'd2: return {32'd0, b};
      4'd3: return {32'd0, (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h};
      4'd4: return {32'd0, h};
      4'd5: return {32'd0, rdata};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] store_model(input logic [3:0] op,
                                              input logic [31:0] sdata);
    if (op == 4'd6) return (sdata & 32'h0000_00FF) * 32'h0101_0101;
    if (op == 4'd7) return (sdata & 32'h0000_FFFF) * 32'h0001_0001;
    return sdata;
  endfunction

  // Write-back and exception outputs are checked on every falling edge.
  always @(negedge clk) begin
    checkOutput("mem_wd", 64'(mem_wd), 64'(exp_wd));
    checkOutput("mem_reg", 64'(mem_reg), 64'(exp_reg));
    checkOutput("mem_wdata", mem_wdata, exp_wdata);
    checkOutput("exc_ade", 64'(exc_ade), 64'(exp_ade));
    if (exp_ade) checkOutput("exc_badvaddr", 64'(exc_badvaddr), 64'(exp_bad));
`ifndef ADDR_EXC_EN
    checkOutput("exc_badvaddr_tied", 64'(exc_badvaddr), 64'd0);
`endif
  end

  // Issue one instruction from EX and play the bus slave for it.
  // flush_mode: 0 none, 1 REQ before addr_ok, 2 last REQ cycle (with addr_ok),
  // 3 first WAIT cycle, 4 accept cycle in IDLE.
  // lit: literal check of mem_wdata (loads/ALU), data_wdata (stores) or
  // exc_badvaddr (misaligned).
  task automatic applyStimulus(input logic [3:0] op, input logic [4:0] wd,
                               input logic rg, input logic [63:0] wdata,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input int req_cycles,
                               input int wait_cycles, input int flush_mode,
                               input logic use_lit, input logic [63:0] lit);
    logic       is_mem;
    logic       is_store;
    logic       mis;
    logic [1:0] sz;
    is_mem   = (op >= 4'd1) && (op <= 4'd8);
    is_store = (op >= 4'd6) && (op <= 4'd8);
    sz       = size_model(op);
`ifdef ADDR_EXC_EN
    mis = is_mem && (((sz == 2'd1) && (addr % 2 != 0)) || ((sz == 2'd2) && (addr % 4 != 0)));
`else
    mis = 1'b0;
`endif
    checkOutput("ex_ready_idle", 64'(ex_ready), 64'd1);
    ex_valid = 1'b1;
    ex_memop = op;
    ex_wd    = wd;
    ex_reg   = rg;
    ex_wdata = wdata;
    ex_addr  = addr;
    ex_sdata = sdata;
    flush_i  = (flush_mode == 4);
    step();
    ex_valid = 1'b0;
    ex_memop = 4'($urandom);
    flush_i  = 1'b0;
    if (!is_mem || flush_mode == 4 || mis) begin
      if (flush_mode != 4) begin
        if (!is_mem) begin
          exp_wd    = wd;
          exp_reg   = rg;
          exp_wdata = wdata;
          if (use_lit) checkOutput("lit_alu_wdata", mem_wdata, lit);
        end else begin
          exp_ade = 1'b1;
          exp_bad = addr;
          if (use_lit) checkOutput("lit_badvaddr", 64'(exc_badvaddr), lit);
        end
      end
      checkOutput("no_data_req", 64'(data_req), 64'd0);
      return;
    end
    if (flush_mode == 1) begin
      checkOutput("data_req_req", 64'(data_req), 64'd1);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      checkOutput("data_req_flushed", 64'(data_req), 64'd0);
      checkOutput("ex_ready_flushed", 64'(ex_ready), 64'd1);
      return;
    end
    for (int r = 1; r <= req_cycles; r++) begin
      checkOutput("data_req", 64'(data_req), 64'd1);
      checkOutput("data_wr", 64'(data_wr), 64'(is_store));
      checkOutput("data_size", 64'(data_size), 64'(sz));
      checkOutput("data_addr", 64'(data_addr), 64'(addr));
      if (is_store) checkOutput("data_wdata", 64'(data_wdata), 64'(store_model(op, sdata)));
      if (is_store && use_lit && r == 1) checkOutput("lit_data_wdata", 64'(data_wdata), lit);
      checkOutput("ex_ready_req", 64'(ex_ready), 64'd0);
      data_rdata = $urandom;
      if (r == req_cycles) begin
        data_addr_ok = 1'b1;
        if (wait_cycles == 0) begin
          data_data_ok = 1'b1;
          data_rdata   = rdata;
        end
        if (flush_mode == 2) flush_i = 1'b1;
      end
      step();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      flush_i      = 1'b0;
    end
    for (int w = 1; w <= wait_cycles; w++) begin
      checkOutput("data_req_wait", 64'(data_req), 64'd0);
      checkOutput("ex_ready_wait", 64'(ex_ready), 64'd0);
      data_rdata = $urandom;
      if (w == 1 && flush_mode == 3) flush_i = 1'b1;
      if (w == wait_cycles) begin
        data_data_ok = 1'b1;
        data_rdata   = rdata;
      end
      step();
      data_data_ok = 1'b0;
      flush_i      = 1'b0;
    end
    if (flush_mode == 0) begin
      exp_wd    = wd;
      exp_reg   = is_store ? 1'b0 : rg;
      exp_wdata = is_store ? 64'd0 : load_model(op, addr, rdata);
      if (use_lit && !is_store) checkOutput("lit_load_wdata", mem_wdata, lit);
    end
    checkOutput("ex_ready_done", 64'(ex_ready), 64'd1);
    checkOutput("data_req_done", 64'(data_req), 64'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    int          fm;
    int          wt;
    ex_valid     = 1'b0;
    ex_wd        = 5'd0;
    ex_reg       = 1'b0;
    ex_wdata     = 64'd0;
    ex_memop     = 4'd0;
    ex_addr      = 32'd0;
    ex_sdata     = 32'd0;
    flush_i      = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    rst          = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_data_req", 64'(data_req), 64'd0);
    checkOutput("rst_data_wr", 64'(data_wr), 64'd0);
    checkOutput("rst_data_size", 64'(data_size), 64'd0);
    checkOutput("rst_data_addr", 64'(data_addr), 64'd0);
    checkOutput("rst_data_wdata", 64'(data_wdata), 64'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 64'd0);
    checkOutput("rst_exc_badvaddr", 64'(exc_badvaddr), 64'd0);
    checkOutput("rst_ex_ready", 64'(ex_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    step();

    // ALU pass-through, then an idle cycle must read as a bubble.
    applyStimulus(4'd0, 5'd3, 1'b1, 64'h0000_0000_1234_5678, 32'd0, 32'd0, 32'd0,
                  1, 0, 0, 1'b1, 64'h0000_0000_1234_5678);
    step();
    // LB at 0x1003: data_req for 2 cycles, data one cycle after addr_ok.
    applyStimulus(4'd1, 5'd7, 1'b1, 64'd0, 32'h0000_1003, 32'd0, 32'h80FF_0000,
                  2, 1, 0, 1'b1, 64'h0000_0000_FFFF_FF80);
    step();
    // SH at 0x2002 replicates the halfword into both lanes.
    applyStimulus(4'd7, 5'd9, 1'b1, 64'd0, 32'h0000_2002, 32'h0000_ABCD, 32'd0,
                  1, 1, 0, 1'b1, 64'h0000_0000_ABCD_ABCD);
    // LW flushed in WAIT drains through DROP with no result.
    applyStimulus(4'd5, 5'd4, 1'b1, 64'd0, 32'h0000_0040, 32'd0, 32'hDEAD_BEEF,
                  1, 3, 3, 1'b0, 64'd0);
    // LHU with addr_ok and data_ok in the same cycle completes immediately.
    applyStimulus(4'd4, 5'd5, 1'b1, 64'd0, 32'h0000_0102, 32'd0, 32'h9876_5432,
                  1, 0, 0, 1'b1, 64'h0000_0000_0000_9876);
    // Flush in IDLE kills an ALU result; flush before addr_ok abandons a load.
    applyStimulus(4'd0, 5'd6, 1'b1, 64'hFFFF_0000_0000_0001, 32'd0, 32'd0, 32'd0,
                  1, 0, 4, 1'b0, 64'd0);
    applyStimulus(4'd3, 5'd6, 1'b1, 64'd0, 32'h0000_0200, 32'd0, 32'h0000_8001,
                  1, 1, 1, 1'b0, 64'd0);
`ifdef ADDR_EXC_EN
    // Misaligned LW raises an address error and never touches the bus.
    applyStimulus(4'd5, 5'd2, 1'b1, 64'd0, 32'h0000_1001, 32'd0, 32'd0,
                  1, 1, 0, 1'b1, 64'h0000_0000_0000_1001);
    checkOutput("ade_no_req", 64'(data_req), 64'd0);
    step();
`endif

    // Reset in the middle of REQ drops data_req at once; a late data_ok is ignored.
    step();
    ex_valid = 1'b1;
    ex_memop = 4'd5;
    ex_wd    = 5'd8;
    ex_reg   = 1'b1;
    ex_addr  = 32'h0000_3000;
    step();
    ex_valid = 1'b0;
    checkOutput("mid_req_data_req", 64'(data_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_req_reset_data_req", 64'(data_req), 64'd0);
    checkOutput("mid_req_reset_ready", 64'(ex_ready), 64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    step();
    data_data_ok = 1'b1;
    data_rdata   = 32'h1234_5678;
    step();
    data_data_ok = 1'b0;
    checkOutput("late_data_ok_req", 64'(data_req), 64'd0);
    step();

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      op   = 4'($urandom_range(0, 15));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
      wt = $urandom_range(0, 3);
      fm = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 4);
      if (fm == 3 && wt == 0) wt = 1;
      applyStimulus(op, 5'($urandom), 1'($urandom), {$urandom, $urandom}, addr,
                    $urandom, $urandom, $urandom_range(1, 3), wt, fm, 1'b0, 64'd0);
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state changes on its rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 ex_valid  in  1  EX presents an instruction this cycle.
REQ-004 ex_ready  out  1  stage accepts; transfer occurs when ex_valid=1 and ex_ready=1 on the same edge.
REQ-005 ex_wd  in  5  destination register; ex_reg  in  1  register-write enable.
REQ-006 ex_wdata  in  64  ALU/HI-LO result; ex_memop  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; 9-15 treated as none.
REQ-007 ex_addr  in  32  effective address; ex_sdata  in  32  store data.
REQ-008 flush_i  in  1  discard the in-flight instruction.
REQ-009 data_req  out  1; data_wr  out  1; data_size  out  2  (0=byte, 1=half, 2=word); data_addr  out  32; data_wdata  out  32.
REQ-010 data_addr_ok  in  1; data_data_ok  in  1; data_rdata  in  32  (SRAM-like data bus).
REQ-011 mem_wd  out  5; mem_reg  out  1; mem_wdata  out  64  registered result to write-back.
REQ-012 exc_ade  out  1  misaligned-access pulse; exc_badvaddr  out  32  faulting address.

Function
REQ-013 FSM states: IDLE, REQ, WAIT, DROP; ex_ready=1 only in IDLE.
REQ-014 IDLE, accept with memop=none: next cycle mem_wd/mem_reg/mem_wdata = ex_wd/ex_reg/ex_wdata (1-cycle latency); stay in IDLE.
REQ-015 IDLE, accept with a load/store: latch ex_* fields; go to REQ; data_req=1 from the next cycle onward.
REQ-016 REQ: hold data_req, data_wr, data_size, data_addr and data_wdata stable; on data_addr_ok=1, drop data_req next cycle and go to WAIT.
REQ-017 WAIT: on data_data_ok=1, present the result on mem_* the next cycle and return to IDLE.
REQ-018 addr_ok and data_ok asserted in the same cycle while in REQ: treat as completion; go directly to IDLE with the result.
REQ-019 Every cycle no result is produced: mem_wd=0, mem_reg=0, mem_wdata=0 (bubble).
REQ-020 Loads, byte lane selection:
  - byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - mem_wdata[63:32]=0; mem_reg=ex_reg.
REQ-021 Stores:
  - SB replicates the byte into all 4 lanes; SH replicates the half into both halves.
  - data_addr = ex_addr unmodified.
  - completion produces mem_reg=0.
REQ-022 flush_i in IDLE: suppress any accept-cycle result; mem_* = 0 next cycle.
REQ-023 flush_i in REQ before addr_ok: drop data_req next cycle; return to IDLE; no result.
REQ-024 flush_i in REQ with addr_ok=1, or in WAIT: go to DROP (or to IDLE if data_ok is asserted that cycle).
REQ-025 DROP: ex_ready=0; wait for data_data_ok; discard data; then go to IDLE; no result.
REQ-026 At most one outstanding bus transaction at any time.

Reset
REQ-027 On rst=0:
  - state goes to IDLE.
  - data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0.
  - mem_wd=0, mem_reg=0, mem_wdata=0.
  - exc_ade=0, exc_badvaddr=0.
REQ-028 Reset asserted mid-transaction abandons it; any later data_data_ok arriving in IDLE is ignored.

Configuration
REQ-029 Macro ADDR_EXC_EN defined: the following are misaligned:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
REQ-030 Misaligned access (ADDR_EXC_EN defined): no bus request; stay in IDLE; next cycle exc_ade=1 for one cycle, exc_badvaddr=ex_addr, mem_reg=0.
REQ-031 ADDR_EXC_EN undefined: addresses are issued unchanged; exc_ade and exc_badvaddr are tied to 0.

Verification
REQ-032 ADDU result: ex_wd=3, ex_reg=1, ex_wdata=0x0000_0000_1234_5678, memop=none -> next cycle mem_wd=3, mem_reg=1, mem_wdata=0x12345678; the following idle cycle all mem_* = 0.
REQ-033 LB at addr 0x1003, addr_ok after 2 cycles, rdata=0x80FF_0000 returned 1 cycle later -> data_size=0, data_req held 2 cycles; mem_wdata=0xFFFF_FF80 exactly one cycle after data_ok.
REQ-034 SH at 0x2002 with sdata=0x0000_ABCD -> data_wr=1, data_size=1, data_wdata=0xABCD_ABCD, data_addr=0x2002; completion gives mem_reg=0.
REQ-035 LW with flush_i asserted in WAIT -> DROP until data_ok; ex_ready=0 throughout; no nonzero mem_* output.
REQ-036 ADDR_EXC_EN defined, LW at 0x1001 -> data_req stays 0; exc_ade=1 for one cycle; exc_badvaddr=0x1001.
REQ-037 rst=0 asserted mid-REQ -> data_req=0 immediately; a later data_ok produces no output.
